seg_mux_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment display driver.
- Generalises the existing two-digit alternating display to NUM_DIGITS digits.
- Adds a runtime refresh divider, a per-digit enable mask, inter-digit blanking (anti-ghosting) and a frame tick.
- Sits between the datapath (switch/sum logic) and the board pins; drives shared segment lines and one common-anode enable per digit.

---
 rtl/seg_mux_driver_pkg.sv | 40 ++++
 rtl/seg_mux_driver_hex_to_seg.sv | 12 +
 rtl/seg_mux_driver.sv | 143 ++++++++++++++
 tb/tb_seg_mux_driver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg_mux_driver_pkg.sv
// Shared types, FSM states and the hex-to-seven-segment table used by the
// multiplexed display driver.
package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam seg_t SEG_OFF_AH = 7'h00;

  // Segment order is {g,f,e,d,c,b,a}; a set bit lights the segment.
  function automatic seg_t hex_to_seg_ah(input nibble_t nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = SEG_OFF_AH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_mux_driver_hex_to_seg.sv
// Combinational hex nibble to active-high segment decoder; output polarity is
// handled by the driver that instantiates it.
module hex_to_seg
  import seg_pkg::*;
(
  input  nibble_t nib_i,
  output seg_t    seg_o
);

  assign seg_o = hex_to_seg_ah(nib_i);

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver: each slot is an all-off blank
// phase followed by a show phase whose pattern is latched once on entry.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int DIV_WIDTH      = 16,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [DIV_WIDTH-1:0]    refresh_div_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   en_o,
  output logic [IDX_W-1:0]        digit_idx_o,
  output logic                    frame_tick_o
);

  localparam seg_t                  SEG_OFF    = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = EN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [DIV_WIDTH-1:0]  BLANK_LAST = (BLANK_CYCLES > 0) ? DIV_WIDTH'(BLANK_CYCLES - 1) : {DIV_WIDTH{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam state_t                ST_RESET   = state_t'((BLANK_CYCLES == 0) ? SHOW : BLANK);

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tick_q, tick_d;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;

  logic                    last_digit;
  logic                    load;
  logic [IDX_W-1:0]        idx_inc;
  logic [IDX_W-1:0]        sel_idx;
  nibble_t                 sel_nib;
  logic                    sel_en;
  seg_t                    sel_seg_ah;
  logic [NUM_DIGITS-1:0]   sel_onehot;

  assign last_digit = (idx_q == IDX_LAST);
  assign idx_inc    = last_digit ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
  // A SHOW-to-SHOW hop (no blank phase) loads the next digit, not the current one.
  assign sel_idx    = (state_q == SHOW) ? idx_inc : idx_q;
  assign sel_onehot = NUM_DIGITS'(1) << sel_idx;

  // Select the nibble and enable bit of the digit about to be shown.
  always_comb begin
    sel_nib = 4'h0;
    sel_en  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sel_nib = (sel_idx == IDX_W'(k)) ? digits_i[4*k +: 4] : sel_nib;
      sel_en  = (sel_idx == IDX_W'(k)) ? digit_en_i[k]      : sel_en;
    end
  end

  hex_to_seg u_hex_to_seg (
    .nib_i (sel_nib),
    .seg_o (sel_seg_ah)
  );

  // Slot sequencing; outputs only change on entry to SHOW or BLANK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + DIV_WIDTH'(1);
    div_d   = div_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    seg_d   = seg_q;
    en_d    = en_q;
    load    = 1'b0;
    case (state_q)
      BLANK: begin
        load = (cnt_q == BLANK_LAST);
      end
      SHOW: begin
        if (cnt_q == div_q) begin
          idx_d  = idx_inc;
          tick_d = last_digit;
          if (BLANK_CYCLES == 0) begin
            load = 1'b1;
          end else begin
            state_d = BLANK;
            cnt_d   = {DIV_WIDTH{1'b0}};
            seg_d   = SEG_OFF;
            en_d    = EN_OFF;
          end
        end else begin
          load = 1'b0;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = {DIV_WIDTH{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        seg_d   = SEG_OFF;
        en_d    = EN_OFF;
      end
    endcase
    if (load) begin
      state_d = SHOW;
      cnt_d   = {DIV_WIDTH{1'b0}};
      div_d   = refresh_div_i;
      seg_d   = sel_en ? (SEG_ACTIVE_LOW ? ~sel_seg_ah : sel_seg_ah) : SEG_OFF;
      en_d    = sel_en ? (EN_ACTIVE_LOW ? ~sel_onehot : sel_onehot) : EN_OFF;
    end else begin
      div_d   = div_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      cnt_q   <= {DIV_WIDTH{1'b0}};
      div_q   <= {DIV_WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      tick_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      en_q    <= EN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign seg_o        = seg_q;
  assign en_o         = en_q;
  assign digit_idx_o  = idx_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed self-checking bench: a 2-digit instance with blanking and a 4-digit
// instance without blanking, checked cycle by cycle against hand-made tables.
module tb_seg_mux_driver;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic        a_rst;
  logic [7:0]  a_digits;
  logic [1:0]  a_mask;
  logic [15:0] a_div;
  logic [6:0]  a_seg;
  logic [1:0]  a_en;
  logic [0:0]  a_idx;
  logic        a_tick;

  logic        b_rst;
  logic [15:0] b_digits;
  logic [3:0]  b_mask;
  logic [15:0] b_div;
  logic [6:0]  b_seg;
  logic [3:0]  b_en;
  logic [1:0]  b_idx;
  logic        b_tick;

  logic [1:0] a3_en  [13] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                              2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
  logic [6:0] a3_seg [13] = '{7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F,
                              7'h7F, 7'h79, 7'h7F, 7'h7F, 7'h40, 7'h7F};
  logic       a3_idx [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [6:0] b_seg_tab [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

  always #5 clk = ~clk;

  seg_mux_driver #(
    .NUM_DIGITS (2), .DIV_WIDTH (16), .BLANK_CYCLES (2),
    .SEG_ACTIVE_LOW (1'b1), .EN_ACTIVE_LOW (1'b1)
  ) u_dut_a (
    .clk (clk), .reset (a_rst), .digits_i (a_digits), .digit_en_i (a_mask),
    .refresh_div_i (a_div), .seg_o (a_seg), .en_o (a_en),
    .digit_idx_o (a_idx), .frame_tick_o (a_tick)
  );

  seg_mux_driver #(
    .NUM_DIGITS (4), .DIV_WIDTH (16), .BLANK_CYCLES (0),
    .SEG_ACTIVE_LOW (1'b1), .EN_ACTIVE_LOW (1'b1)
  ) u_dut_b (
    .clk (clk), .reset (b_rst), .digits_i (b_digits), .digit_en_i (b_mask),
    .refresh_div_i (b_div), .seg_o (b_seg), .en_o (b_en),
    .digit_idx_o (b_idx), .frame_tick_o (b_tick)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of the 2-digit, 2-blank, div=3 frame at cycle k after reset.
  task automatic exp_a(input int k, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [1:0] mask, output logic [1:0] en,
                       output logic [6:0] seg, output logic idx, output logic tk);
    int p;
    p   = k % 12;
    tk  = (k > 0) && (p == 0);
    idx = (p >= 6);
    if (p < 2 || (p >= 6 && p < 8)) begin
      en = 2'b11; seg = 7'h7F;
    end else if (p < 6) begin
      en = mask[0] ? 2'b10 : 2'b11; seg = mask[0] ? s0 : 7'h7F;
    end else begin
      en = mask[1] ? 2'b01 : 2'b11; seg = mask[1] ? s1 : 7'h7F;
    end
  endtask

  task automatic run_a(input string tag, input int n, input logic [6:0] s0_early,
                       input logic [6:0] s0_late, input logic [6:0] s1,
                       input logic [1:0] mask, input int chg_k, input logic [7:0] new_digits);
    logic [1:0] en;
    logic [6:0] seg;
    logic       idx;
    logic       tk;
    a_rst = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_a(k, (k < 12) ? s0_early : s0_late, s1, mask, en, seg, idx, tk);
      check_eq({tag, "_en"},   {14'd0, a_en},   {14'd0, en});
      check_eq({tag, "_seg"},  {9'd0, a_seg},   {9'd0, seg});
      check_eq({tag, "_idx"},  {15'd0, a_idx},  {15'd0, idx});
      check_eq({tag, "_tick"}, {15'd0, a_tick}, {15'd0, tk});
      check_eq({tag, "_en_not_both"}, {15'd0, (a_en != 2'b00)}, 16'd1);
      if (k == chg_k) a_digits = new_digits;
      step();
    end
  endtask

  initial begin
    a_rst = 1'b1; a_digits = 8'h10; a_mask = 2'b11; a_div = 16'd3;
    b_rst = 1'b1; b_digits = 16'h3210; b_mask = 4'hF; b_div = 16'd0;
    step();
    check_eq("a_rst_seg",  {9'd0, a_seg},   16'h007F);
    check_eq("a_rst_en",   {14'd0, a_en},   16'h0003);
    check_eq("a_rst_idx",  {15'd0, a_idx},  16'h0000);
    check_eq("a_rst_tick", {15'd0, a_tick}, 16'h0000);

    // Basic two-digit frame, three frames long.
    run_a("a1", 36, 7'h40, 7'h40, 7'h79, 2'b11, -1, 8'h10);

    // Digit 1 masked off; its slot stays dark but keeps its length.
    a_mask = 2'b01; a_rst = 1'b1; step();
    run_a("a2", 24, 7'h40, 7'h40, 7'h79, 2'b01, -1, 8'h10);

    // refresh_div drops to 0 in the middle of digit 0's SHOW.
    a_mask = 2'b11; a_rst = 1'b1; step(); a_rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      check_eq("a3_en",   {14'd0, a_en},  {14'd0, a3_en[k]});
      check_eq("a3_seg",  {9'd0, a_seg},  {9'd0, a3_seg[k]});
      check_eq("a3_idx",  {15'd0, a_idx}, {15'd0, a3_idx[k]});
      check_eq("a3_tick", {15'd0, a_tick}, {15'd0, (k == 9)});
      if (k == 3) a_div = 16'd0;
      step();
    end

    // Digits change mid-SHOW; takes effect from the next slot only.
    a_div = 16'd3; a_rst = 1'b1; step();
    run_a("a4", 18, 7'h40, 7'h12, 7'h08, 2'b11, 3, 8'hA5);

    // Reset pulse during digit 1's SHOW restarts from digit 0's BLANK.
    a_digits = 8'h10; a_rst = 1'b1; step();
    run_a("a5pre", 10, 7'h40, 7'h40, 7'h79, 2'b11, -1, 8'h10);
    check_eq("a5_pre_en", {14'd0, a_en}, 16'h0001);
    a_rst = 1'b1; step();
    run_a("a5", 14, 7'h40, 7'h40, 7'h79, 2'b11, -1, 8'h10);

    // Four digits, no blanking, 1-cycle SHOW.
    check_eq("b_rst_seg",  {9'd0, b_seg},   16'h007F);
    check_eq("b_rst_en",   {12'd0, b_en},   16'h000F);
    check_eq("b_rst_idx",  {14'd0, b_idx},  16'h0000);
    check_eq("b_rst_tick", {15'd0, b_tick}, 16'h0000);
    b_rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] exp_en;
      int d;
      step();
      d = k % 4;
      exp_en = 4'hF ^ (4'h1 << d);
      check_eq("b_en",   {12'd0, b_en},   {12'd0, exp_en});
      check_eq("b_seg",  {9'd0, b_seg},   {9'd0, b_seg_tab[d]});
      check_eq("b_idx",  {14'd0, b_idx},  16'(d));
      check_eq("b_tick", {15'd0, b_tick}, {15'd0, (d == 0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
